fifo_write_arbiter: RTL



---
 rtl/fifo_write_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin arbiter sharing one FIFO write port among NUM_REQ producers
module fifo_write_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_overflow,
    output logic [ID_W-1:0]               grant_id,
    output logic [7:0]                    drop_cnt
);

    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0] data_q, data_d;
    logic [ID_W-1:0]       gid_q, gid_d;
    logic [7:0]            drop_q, drop_d;

    logic                  issue_ok;
    logic                  win_found;
    logic [ID_W-1:0]       win_id;
    logic [ID_W-1:0]       cand;
    logic                  xfer;
    int                    idx;

    // Never hand out the last free slot while the in-flight write is about to take it.
    assign issue_ok = !fifo_full && !(wr_en_q && fifo_almostfull);

    // Scan upward from the round-robin pointer for the first valid requester.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx  = (int'(rr_ptr_q) + k) % NUM_REQ;
            cand = ID_W'(idx);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Ready is one-hot on the winner only when an issue is allowed and never during reset.
    assign xfer      = rst_n && issue_ok && win_found;
    assign req_ready = xfer ? (NUM_REQ'(1) << win_id) : '0;

    // Next-state for the output stage, pointer and overflow counter.
    always_comb begin
        wr_en_d  = 1'b0;
        data_d   = data_q;
        gid_d    = gid_q;
        rr_ptr_d = rr_ptr_q;
        drop_d   = drop_q;
        if (xfer) begin
            wr_en_d  = 1'b1;
            data_d   = req_data[int'(win_id)*FIFO_WIDTH +: FIFO_WIDTH];
            gid_d    = win_id;
            rr_ptr_d = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + ID_W'(1);
        end
        if (fifo_overflow && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // State registers; reset clears the in-flight write immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            wr_en_q  <= 1'b0;
            data_q   <= '0;
            gid_q    <= '0;
            drop_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_en_q  <= wr_en_d;
            data_q   <= data_d;
            gid_q    <= gid_d;
            drop_q   <= drop_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign grant_id     = gid_q;
    assign drop_cnt     = drop_q;

endmodule
